program_loader: RTL and testbench

- Loads a program image from a byte-serial host link into instruction memory through that memory's write port.
- Holds the single-cycle CPU in reset (cpu_hold) until the image has loaded and its checksum has been verified.
- It is the writer side of the instruction memory; the CPU is the reader.
- Image format, all multi-byte fields big-endian: 4-byte word count N, then N 32-bit instruction words, then a 4-byte checksum equal to the XOR of all N words.

---
 rtl/program_loader.sv | 101 ++++++++++
 tb/tb_program_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-serial program image loader: writes instruction words into IMEM and
// holds the CPU in reset until the image checksum has been verified.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int IW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t         state, stateNext;
    logic [1:0]     byteCnt;
    logic [23:0]    shiftReg;
    logic [IW-1:0]  wordIdx, wordCnt, idxNext;
    logic [31:0]    xorAcc, field;
    logic           accept, fieldDone, lastWord, restart;

    assign accept    = byte_valid && byte_ready;
    assign fieldDone = accept && (byteCnt == 2'd3);
    assign field     = {shiftReg, byte_in};
    assign idxNext   = wordIdx + IW'(1);
    assign lastWord  = (idxNext == wordCnt);
    assign restart   = start && (state inside {IDLE, DONE, ERR});

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE, ERR: if (start) stateNext = LEN;
            LEN: if (fieldDone) begin
                if (field > 32'(MAX_WORDS)) stateNext = ERR;
                else if (field == 32'd0)    stateNext = CSUM;
                else                        stateNext = DATA;
            end
            DATA: if (fieldDone && lastWord) stateNext = CSUM;
            CSUM: if (fieldDone) stateNext = (field == xorAcc) ? DONE : ERR;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_data   <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byteCnt    <= 2'd0;
            shiftReg   <= 24'd0;
            wordIdx    <= '0;
            wordCnt    <= '0;
            xorAcc     <= 32'd0;
        end else begin
            // Status outputs follow the next state so they are registered yet
            // line up exactly with the state register.
            mem_we     <= 1'b0;
            byte_ready <= stateNext inside {LEN, DATA, CSUM};
            done       <= (stateNext == DONE);
            error      <= (stateNext == ERR);
            cpu_hold   <= (stateNext != DONE);
            if (restart) begin
                byteCnt <= 2'd0;
                wordIdx <= '0;
                wordCnt <= '0;
                xorAcc  <= 32'd0;
            end
            if (accept) begin
                byteCnt  <= byteCnt + 2'd1;
                shiftReg <= {shiftReg[15:0], byte_in};
            end
            if (fieldDone && state == LEN)
                wordCnt <= field[IW-1:0];
            if (fieldDone && state == DATA) begin
                mem_we   <= 1'b1;
                mem_addr <= BASE_ADDR + (32'(wordIdx) << 2);
                mem_data <= field;
                wordIdx  <= idxNext;
                xorAcc   <= xorAcc ^ field;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected IMEM writes are queued by the
// stimulus and popped by an independent monitor whenever mem_we is seen.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_data;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t expQ[$];
    int  compared = 0;
    int  mismatched = 0;

    program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_data);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_data", mem_data, e.d);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap, input logic st);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        start      = st;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL byte_timeout: got byte_ready 0 expected 1");
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit rnd, input int stIdx);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[31 - 8*i -: 8];
            sendByte(b, rnd ? int'($urandom_range(0, 5)) : 0, (i == stIdx));
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResult(input logic ok);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("error", {31'd0, error}, {31'd0, !ok});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        chk("byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("pending_writes", expQ.size(), 32'd0);
    endtask

    task automatic pushImage2();
        expQ.push_back('{a: 32'h0, d: 32'h2008_0005});
        expQ.push_back('{a: 32'h4, d: 32'h2009_000A});
    endtask

    task automatic checkReset();
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
    endtask

    initial begin
        // 1: reset with random inputs
        repeat (4) begin
            @(negedge clk);
            start      = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_in    = 8'($urandom);
        end
        checkReset();
        start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: good two-word image, back-to-back
        pushImage2();
        pulseStart();
        sendWord(32'd2, 0, -1);
        sendWord(32'h2008_0005, 0, -1);
        sendWord(32'h2009_000A, 0, -1);
        sendWord(32'h0001_000F, 0, -1);
        checkResult(1'b1);

        // 3: bad checksum, then reload the correct image
        pushImage2();
        pulseStart();
        chk("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        sendWord(32'd2, 0, -1);
        sendWord(32'h2008_0005, 0, -1);
        sendWord(32'h2009_000A, 0, -1);
        sendWord(32'h0001_000E, 0, -1);
        checkResult(1'b0);
        pushImage2();
        pulseStart();
        sendWord(32'd2, 0, -1);
        sendWord(32'h2008_0005, 0, -1);
        sendWord(32'h2009_000A, 0, -1);
        sendWord(32'h0001_000F, 0, -1);
        checkResult(1'b1);

        // 4: length MAX_WORDS+1 rejected right after the 4th byte
        pulseStart();
        sendWord(32'h0000_0401, 0, -1);
        checkResult(1'b0);
        repeat (3) @(negedge clk);
        chk("err_hold_byte_ready", {31'd0, byte_ready}, 32'd0);

        // 5: random gaps plus a start pulse mid-DATA, then N=0
        pushImage2();
        pulseStart();
        sendWord(32'd2, 1, -1);
        sendWord(32'h2008_0005, 1, 1);
        sendWord(32'h2009_000A, 1, -1);
        sendWord(32'h0001_000F, 1, -1);
        checkResult(1'b1);
        pulseStart();
        sendWord(32'd0, 0, -1);
        sendWord(32'd0, 0, -1);
        checkResult(1'b1);

        // 6: reset after the 6th DATA byte, then a fresh full load
        expQ.push_back('{a: 32'h0, d: 32'h2008_0005});
        pulseStart();
        sendWord(32'd2, 0, -1);
        sendWord(32'h2008_0005, 0, -1);
        sendByte(8'h20, 0, 1'b0);
        sendByte(8'h09, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkReset();
        chk("rst_pending_writes", expQ.size(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pushImage2();
        pulseStart();
        sendWord(32'd2, 0, -1);
        sendWord(32'h2008_0005, 0, -1);
        sendWord(32'h2009_000A, 0, -1);
        sendWord(32'h0001_000F, 0, -1);
        checkResult(1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
